sprite_layer_mixer: RTL and testbench

//  Parametrised successor to the 2:1 sprite colour mux. Composites M sprite layers over a

---
 rtl/sprite_pkg.sv | 14 +
 rtl/sprite_priority_enc.sv | 31 +++
 rtl/sprite_layer_mixer.sv | 138 +++++++++++++
 tb/tb_sprite_layer_mixer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// ============================================================================
//  Module  : sprite_pkg
//  Brief   : Shared colour types and constants for the sprite compositing path.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package sprite_pkg;
    localparam int COLOUR_W = 12;
    typedef logic [COLOUR_W-1:0] colour_t;
    localparam colour_t BLACK = 12'h000;
endpackage

`default_nettype wire

// File: rtl/sprite_priority_enc.sv
// ============================================================================
//  Module  : sprite_priority_enc
//  Brief   : Combinational lowest-set-bit encoder selecting the topmost opaque layer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_priority_enc #(
    parameter int  M = 4,
    localparam int B = $clog2(M)
) (
    input  logic [M-1:0] opaque_i,
    output logic         any_o,
    output logic [B-1:0] idx_o
);

    // Scanning downwards lets the lowest index overwrite any higher one.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (opaque_i[i]) begin
                any_o = 1'b1;
                idx_o = B'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sprite_layer_mixer.sv
// ============================================================================
//  Module  : sprite_layer_mixer
//  Brief   : Two-stage M-layer sprite compositor with sync realignment and
//            sticky per-frame collision flags.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_layer_mixer
    import sprite_pkg::*;
#(
    parameter int  M      = 4,
    parameter int  VS_POL = 0,
    localparam int B      = $clog2(M)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [M*COLOUR_W-1:0] layer_colour,
    input  logic [M-1:0]          layer_hit,
    input  logic [M-1:0]          layer_en,
    input  colour_t               transparent_key,
    input  colour_t               bg_colour,
    input  logic                  de_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    output colour_t               colour_data,
    output logic [B-1:0]          top_layer,
    output logic                  bg_sel,
    output logic                  de_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic [M-1:0]          collision
);

    localparam logic C_VS_ACT   = (VS_POL != 0);
    localparam logic C_SYNC_IDL = ~C_VS_ACT;

    // Stage 1
    logic [M*COLOUR_W-1:0] colour_q;
    logic [M-1:0]          opaque_d, opaque_q;
    colour_t               bg_q;
    logic                  de1_q, hs1_q, vs1_q;

    // Stage 2
    colour_t               colour_data_q, colour_data_d;
    logic [B-1:0]          top_q, top_d;
    logic                  bg_sel_q, bg_sel_d;
    logic                  de2_q, hs2_q, vs2_q;
    logic [M-1:0]          acc_q, acc_d;
    logic [M-1:0]          coll_q, coll_d;

    logic                  w_any;
    logic [B-1:0]          w_idx;
    logic [M-1:0]          w_contrib;
    logic                  w_vs_edge;

    for (genvar i = 0; i < M; i++) begin : g_opaque
        assign opaque_d[i] = layer_hit[i] & layer_en[i]
                           & (layer_colour[COLOUR_W*i +: COLOUR_W] != transparent_key);
    end

    sprite_priority_enc #(.M(M)) u_prio (
        .opaque_i (opaque_q),
        .any_o    (w_any),
        .idx_o    (w_idx)
    );

    // vs2_q holds the previous stage-1 vsync, so it doubles as the edge history.
    assign w_vs_edge = (vs1_q == C_VS_ACT) && (vs2_q != C_VS_ACT);
    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign w_contrib = (de1_q && ((opaque_q & (opaque_q - 1'b1)) != '0)) ? opaque_q : '0;

    always_comb begin
        colour_data_d = BLACK;
        top_d         = '0;
        bg_sel_d      = 1'b1;
        acc_d         = acc_q | w_contrib;
        coll_d        = coll_q;
        if (de1_q) begin
            if (w_any) begin
                colour_data_d = colour_q[COLOUR_W*w_idx +: COLOUR_W];
                top_d         = w_idx;
                bg_sel_d      = 1'b0;
            end else begin
                colour_data_d = bg_q;
            end
        end
        if (w_vs_edge) begin
            coll_d = acc_q | w_contrib;
            acc_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colour_q      <= '0;
            opaque_q      <= '0;
            bg_q          <= BLACK;
            de1_q         <= 1'b0;
            hs1_q         <= C_SYNC_IDL;
            vs1_q         <= C_SYNC_IDL;
            colour_data_q <= BLACK;
            top_q         <= '0;
            bg_sel_q      <= 1'b1;
            de2_q         <= 1'b0;
            hs2_q         <= C_SYNC_IDL;
            vs2_q         <= C_SYNC_IDL;
            acc_q         <= '0;
            coll_q        <= '0;
        end else begin
            colour_q      <= layer_colour;
            opaque_q      <= opaque_d;
            bg_q          <= bg_colour;
            de1_q         <= de_in;
            hs1_q         <= hsync_in;
            vs1_q         <= vsync_in;
            colour_data_q <= colour_data_d;
            top_q         <= top_d;
            bg_sel_q      <= bg_sel_d;
            de2_q         <= de1_q;
            hs2_q         <= hs1_q;
            vs2_q         <= vs1_q;
            acc_q         <= acc_d;
            coll_q        <= coll_d;
        end
    end

    assign colour_data = colour_data_q;
    assign top_layer   = top_q;
    assign bg_sel      = bg_sel_q;
    assign de_out      = de2_q;
    assign hsync_out   = hs2_q;
    assign vsync_out   = vs2_q;
    assign collision   = coll_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_layer_mixer.sv
// ============================================================================
//  Module  : tb_sprite_layer_mixer
//  Brief   : Scoreboard bench for sprite_layer_mixer (M=4, active-low vsync).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sprite_layer_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] layer_colour = '0;
    logic [3:0]  layer_hit = '0;
    logic [3:0]  layer_en = 4'hF;
    logic [11:0] transparent_key = 12'hF0F;
    logic [11:0] bg_colour = 12'h00A;
    logic        de_in = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [11:0] colour_data;
    logic [1:0]  top_layer;
    logic        bg_sel, de_out, hsync_out, vsync_out;
    logic [3:0]  collision;

    sprite_layer_mixer #(.M(4), .VS_POL(0)) dut (
        .clk             (clk),
        .rst             (rst),
        .layer_colour    (layer_colour),
        .layer_hit       (layer_hit),
        .layer_en        (layer_en),
        .transparent_key (transparent_key),
        .bg_colour       (bg_colour),
        .de_in           (de_in),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .colour_data     (colour_data),
        .top_layer       (top_layer),
        .bg_sel          (bg_sel),
        .de_out          (de_out),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .collision       (collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [11:0] colour;
        logic [1:0]  top;
        logic        bg;
        logic        de, hs, vs;
        logic        chk_col;
        logic [3:0]  col;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops every expectation whose due cycle has arrived.
    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.due < cyc) chk("sb_late", 32'(e.due), 32'(cyc));
                chk("colour_data", 32'(colour_data), 32'(e.colour));
                chk("top_layer",   32'(top_layer),   32'(e.top));
                chk("bg_sel",      32'(bg_sel),      32'(e.bg));
                chk("de_out",      32'(de_out),      32'(e.de));
                chk("hsync_out",   32'(hsync_out),   32'(e.hs));
                chk("vsync_out",   32'(vsync_out),   32'(e.vs));
                if (e.chk_col) chk("collision", 32'(collision), 32'(e.col));
            end
        end
    end

    // Drive one pixel and queue its expected response two clocks later.
    task automatic pix(input logic [47:0] col, input logic [3:0] hit, input logic [3:0] en,
                       input logic de, input logic hs, input logic vs,
                       input logic [11:0] ec, input logic [1:0] et, input logic ebg,
                       input logic cc, input logic [3:0] ecol);
        exp_t e;
        @(posedge clk);
        #1;
        layer_colour = col;
        layer_hit    = hit;
        layer_en     = en;
        de_in        = de;
        hsync_in     = hs;
        vsync_in     = vs;
        e.due = cyc + 2; e.colour = ec; e.top = et; e.bg = ebg;
        e.de = de; e.hs = hs; e.vs = vs; e.chk_col = cc; e.col = ecol;
        q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_colour"}, 32'(colour_data), 32'h000);
        chk({tag, "_top"},    32'(top_layer),   32'h0);
        chk({tag, "_bg"},     32'(bg_sel),      32'h1);
        chk({tag, "_de"},     32'(de_out),      32'h0);
        chk({tag, "_hs"},     32'(hsync_out),   32'h1);
        chk({tag, "_vs"},     32'(vsync_out),   32'h1);
        chk({tag, "_col"},    32'(collision),   32'h0);
    endtask

    localparam logic [47:0] C_T2   = {12'h000, 12'h456, 12'h123, 12'h000};
    localparam logic [47:0] C_T3   = {12'h000, 12'h000, 12'h0F0, 12'hF0F};
    localparam logic [47:0] C_ALL  = {12'h444, 12'h333, 12'h222, 12'h111};
    localparam logic [47:0] C_OVL  = {12'hABC, 12'h000, 12'h0F0, 12'h000};

    initial begin
        #12;
        check_reset_state("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Background, priority, key, disabled layer, blanking with hsync toggle
        pix('0,    4'b0000, 4'hF, 1, 1, 1, 12'h00A, 2'd0, 1, 1, 4'b0000);
        pix(C_T2,  4'b0110, 4'hF, 1, 1, 1, 12'h123, 2'd1, 0, 1, 4'b0000);
        pix(C_T3,  4'b0011, 4'hF, 1, 1, 1, 12'h0F0, 2'd1, 0, 1, 4'b0000);
        pix(C_T3,  4'b0011, 4'hD, 1, 1, 1, 12'h00A, 2'd0, 1, 1, 4'b0000);
        pix(C_ALL, 4'b1111, 4'hF, 0, 0, 1, 12'h000, 2'd0, 1, 1, 4'b0000);
        pix(C_ALL, 4'b1111, 4'hF, 0, 1, 1, 12'h000, 2'd0, 1, 1, 4'b0000);
        // Frame edge reports the 0110 overlap seen earlier (all-hit pixel had de=0)
        pix('0,    4'b0000, 4'hF, 0, 1, 0, 12'h000, 2'd0, 1, 1, 4'b0110);
        pix('0,    4'b0000, 4'hF, 0, 1, 1, 12'h000, 2'd0, 1, 1, 4'b0110);
        // Overlap 1010 for three pixels, held collision until the next edge
        for (int k = 0; k < 3; k++)
            pix(C_OVL, 4'b1010, 4'hF, 1, 1, 1, 12'h0F0, 2'd1, 0, 1, 4'b0110);
        pix('0,    4'b0000, 4'hF, 0, 1, 0, 12'h000, 2'd0, 1, 1, 4'b1010);
        pix('0,    4'b0000, 4'hF, 0, 1, 0, 12'h000, 2'd0, 1, 1, 4'b1010);
        pix(C_ALL, 4'b0001, 4'hF, 1, 1, 1, 12'h111, 2'd0, 0, 1, 4'b1010);
        pix(C_ALL, 4'b0100, 4'hF, 1, 1, 1, 12'h333, 2'd2, 0, 1, 4'b1010);
        pix(C_ALL, 4'b0100, 4'hF, 1, 1, 1, 12'h333, 2'd2, 0, 1, 4'b1010);

        // Asynchronous reset between edges while collision is non-zero
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        check_reset_state("arst");
        de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; layer_hit = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Disabled overlap never collides; frame without overlap reports zero
        pix(C_OVL, 4'b1010, 4'b0111, 1, 1, 1, 12'h0F0, 2'd1, 0, 1, 4'b0000);
        pix(C_ALL, 4'b1000, 4'hF, 1, 1, 1, 12'h444, 2'd3, 0, 1, 4'b0000);
        pix('0,    4'b0000, 4'hF, 0, 1, 0, 12'h000, 2'd0, 1, 1, 4'b0000);
        pix('0,    4'b0000, 4'hF, 0, 1, 1, 12'h000, 2'd0, 1, 1, 4'b0000);

        for (int t = 0; t < 20 && q.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_drain: %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
